// File: rtl/tea_pkg.sv
// Shared TEA constants, widths, FSM state type and key/mix helpers.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;
  localparam int BLK_W  = 64;
  localparam int HALF_W = 32;
  localparam int KEY_W  = 128;

  typedef logic [HALF_W-1:0] word_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Key word idx: k0 = [31:0] ... k3 = [127:96].
  function automatic word_t key_word(input logic [KEY_W-1:0] k, input logic [1:0] idx);
    return k[HALF_W*idx +: HALF_W];
  endfunction

  // TEA Feistel mix term; all arithmetic wraps modulo 2^32, right shift is logical.
  function automatic word_t tea_mix(input word_t v, input word_t s, input word_t ka, input word_t kb);
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_round.sv
// One combinational TEA round, encrypt or decrypt selected by mode.
// Encrypt pre-increments sum; decrypt uses sum as given and post-decrements it.
module tea_round
  import tea_pkg::*;
#(
  parameter logic [31:0] DELTA = TEA_DELTA
) (
  input  logic [31:0]  v0,
  input  logic [31:0]  v1,
  input  logic [127:0] key,
  input  logic [31:0]  sum,
  input  logic         mode,
  output logic [31:0]  v0_nxt,
  output logic [31:0]  v1_nxt,
  output logic [31:0]  sum_nxt
);

  word_t k0, k1, k2, k3;

  assign k0 = key_word(key, 2'd0);
  assign k1 = key_word(key, 2'd1);
  assign k2 = key_word(key, 2'd2);
  assign k3 = key_word(key, 2'd3);

  // Half-round order flips between directions; each half uses the freshly updated other half.
  always_comb begin
    v0_nxt  = v0;
    v1_nxt  = v1;
    sum_nxt = sum;
    if (mode) begin
      sum_nxt = sum + DELTA;
      v0_nxt  = v0 + tea_mix(v1, sum_nxt, k0, k1);
      v1_nxt  = v1 + tea_mix(v0_nxt, sum_nxt, k2, k3);
    end else begin
      v1_nxt  = v1 - tea_mix(v0, sum, k2, k3);
      v0_nxt  = v0 - tea_mix(v1_nxt, sum, k0, k1);
      sum_nxt = sum - DELTA;
    end
  end

endmodule

// File: rtl/tea_iter_core.sv
// Iterative TEA encrypt/decrypt engine: UNROLL rounds per clock, ROUNDS total.
// Optional macro TEA_KEY_LATCH_EN registers the key on accept; without it the
// key port must stay stable from accept until the output handshake.
module tea_iter_core
  import tea_pkg::*;
#(
  parameter int          ROUNDS = 32,
  parameter int          UNROLL = 1,
  parameter logic [31:0] DELTA  = TEA_DELTA
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         encrypt,
  input  logic [63:0]  inBlock64,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  outBlock64
);

  localparam int STEPS = (UNROLL > 0) ? ROUNDS / UNROLL : 1;
  localparam int CNT_W = (STEPS > 0) ? $clog2(STEPS + 1) : 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(STEPS - 1);
  localparam logic [31:0]      SUM_DEC = 32'(DELTA * ROUNDS);

  generate
    if (ROUNDS < 1 || UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_params
      $error("tea_iter_core: ROUNDS must be >= 1 and divisible by UNROLL");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [31:0]      v0_q, v1_q, sum_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      out_q;
  logic [127:0]     key_use;

`ifdef TEA_KEY_LATCH_EN
  logic [127:0] key_q;

  // Capture the key with the block so the source may move on right after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            key_q <= '0;
    else if (state == IDLE && in_valid) key_q <= key;
  end

  assign key_use = key_q;
`else
  assign key_use = key;
`endif

  // Round chain: stage u feeds stage u+1 within one clock.
  logic [31:0] c_v0  [UNROLL+1];
  logic [31:0] c_v1  [UNROLL+1];
  logic [31:0] c_sum [UNROLL+1];

  assign c_v0[0]  = v0_q;
  assign c_v1[0]  = v1_q;
  assign c_sum[0] = sum_q;

  generate
    for (genvar u = 0; u < UNROLL; u++) begin : g_round
      tea_round #(.DELTA(DELTA)) u_round (
        .v0      (c_v0[u]),
        .v1      (c_v1[u]),
        .key     (key_use),
        .sum     (c_sum[u]),
        .mode    (mode_q),
        .v0_nxt  (c_v0[u+1]),
        .v1_nxt  (c_v1[u+1]),
        .sum_nxt (c_sum[u+1])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; IDLE is only re-entered after the output handshake.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (cnt_q == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in RUN, publish the result on the final RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q   <= '0;
      v1_q   <= '0;
      sum_q  <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
      out_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            v0_q   <= inBlock64[31:0];
            v1_q   <= inBlock64[63:32];
            mode_q <= encrypt;
            sum_q  <= encrypt ? 32'd0 : SUM_DEC;
            cnt_q  <= '0;
          end
        end
        RUN: begin
          v0_q  <= c_v0[UNROLL];
          v1_q  <= c_v1[UNROLL];
          sum_q <= c_sum[UNROLL];
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) out_q <= {c_v1[UNROLL], c_v0[UNROLL]};
        end
        default: ;
      endcase
    end
  end

  assign outBlock64 = out_q;

endmodule

// File: tb/tb_tea_iter_core.sv
// Directed bench for tea_iter_core: two instances (UNROLL=1 and UNROLL=4) share
// the input stimulus; known-answer table, round trips, backpressure and reset abort.
module tb_tea_iter_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         encrypt = 1'b0;
  logic [63:0]  blk = '0;
  logic [127:0] key = '0;
  logic         out_ready = 1'b0;

  logic         in_ready1, out_valid1, in_ready4, out_valid4;
  logic [63:0]  out1, out4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tea_iter_core #(.ROUNDS(32), .UNROLL(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .encrypt(encrypt), .inBlock64(blk), .key(key),
    .out_valid(out_valid1), .out_ready(out_ready), .outBlock64(out1)
  );

  tea_iter_core #(.ROUNDS(32), .UNROLL(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .encrypt(encrypt), .inBlock64(blk), .key(key),
    .out_valid(out_valid4), .out_ready(out_ready), .outBlock64(out4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Straight C-style TEA reference, 32 rounds.
  function automatic logic [63:0] tea_ref(input logic [127:0] k, input logic [63:0] b, input logic enc);
    logic [31:0] v0, v1, s, k0, k1, k2, k3;
    v0 = b[31:0];  v1 = b[63:32];
    k0 = k[31:0];  k1 = k[63:32]; k2 = k[95:64]; k3 = k[127:96];
    if (enc) begin
      s = 32'd0;
      for (int r = 0; r < 32; r++) begin
        s  = s + 32'h9E3779B9;
        v0 = v0 + (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
        v1 = v1 + (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
      end
    end else begin
      s = 32'hC6EF3720;
      for (int r = 0; r < 32; r++) begin
        v1 = v1 - (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
        v0 = v0 - (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
        s  = s - 32'h9E3779B9;
      end
    end
    return {v1, v0};
  endfunction

  // One full transaction on both instances: accept, latency, result, optional hold, handshake.
  task automatic run_block(input logic [127:0] k, input logic [63:0] b, input logic enc,
                           input logic [63:0] exp, input int hold, output logic [63:0] res);
    int lat1, lat4, cyc;
    logic [63:0] h1, h4;
    @(negedge clk);
    chk("in_ready_idle_u1", {63'd0, in_ready1}, 64'd1);
    chk("in_ready_idle_u4", {63'd0, in_ready4}, 64'd1);
    key = k; blk = b; encrypt = enc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; blk = ~b; encrypt = ~enc;
`ifdef TEA_KEY_LATCH_EN
    key = ~k;
`endif
    lat1 = 0; lat4 = 0; cyc = 0;
    while ((lat1 == 0 || lat4 == 0) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid1 && lat1 == 0) lat1 = cyc;
      if (out_valid4 && lat4 == 0) lat4 = cyc;
    end
    chk("latency_u1", 64'(lat1), 64'd32);
    chk("latency_u4", 64'(lat4), 64'd8);
    chk("result_u1", out1, exp);
    chk("result_u4", out4, exp);
    h1 = out1; h4 = out4;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = i[0];
      blk = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("hold_out_u1", out1, h1);
      chk("hold_out_u4", out4, h4);
      chk("hold_ctl_u1", {62'd0, out_valid1, in_ready1}, 64'd2);
      chk("hold_ctl_u4", {62'd0, out_valid4, in_ready4}, 64'd2);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_ctl_u1", {62'd0, out_valid1, in_ready1}, 64'd1);
    chk("post_hs_ctl_u4", {62'd0, out_valid4, in_ready4}, 64'd1);
    res = h1;
  endtask

  typedef struct {
    logic [127:0] k;
    logic [63:0]  b;
    logic         enc;
    logic [63:0]  exp;
    int           hold;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0]  r, c, b;
    logic [127:0] k;

    // Known answers, then patterned vectors checked against the reference.
    tbl[0] = '{128'd0, 64'd0, 1'b1, 64'h94BAA940_41EA3A0A, 0};
    tbl[1] = '{128'd0, 64'h94BAA940_41EA3A0A, 1'b0, 64'd0, 0};
    tbl[2] = '{{4{32'hFFFF_FFFF}}, {2{32'hFFFF_FFFF}}, 1'b1, 64'd0, 10};
    tbl[3] = '{{4{32'h5555_AAAA}}, 64'hAAAA_5555_0F0F_F0F0, 1'b0, 64'd0, 0};
    tbl[4] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 64'h0000_0001_8000_0000, 1'b1, 64'd0, 0};
    tbl[5] = '{128'h0000_0001_0000_0000_0000_0000_8000_0000, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'd0, 3};
    for (int i = 2; i < 6; i++) tbl[i].exp = tea_ref(tbl[i].k, tbl[i].b, tbl[i].enc);

    // Reset values while rst is held.
    #1;
    chk("reset_ctl_u1", {62'd0, out_valid1, in_ready1}, 64'd1);
    chk("reset_ctl_u4", {62'd0, out_valid4, in_ready4}, 64'd1);
    chk("reset_out_u1", out1, 64'd0);
    chk("reset_out_u4", out4, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_block(tbl[i].k, tbl[i].b, tbl[i].enc, tbl[i].exp, tbl[i].hold, r);

    // Random encrypt/decrypt round trips.
    for (int i = 0; i < 12; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom};
      c = tea_ref(k, b, 1'b1);
      run_block(k, b, 1'b1, c, 0, r);
      run_block(k, r, 1'b0, b, 0, r);
    end

    // Reset abort partway through RUN; the held output from the last block must clear.
    @(negedge clk);
    key = {4{32'h1357_9BDF}}; blk = 64'h0011_2233_4455_6677; encrypt = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_ctl_u1", {62'd0, out_valid1, in_ready1}, 64'd1);
    chk("abort_ctl_u4", {62'd0, out_valid4, in_ready4}, 64'd1);
    chk("abort_out_u1", out1, 64'd0);
    chk("abort_out_u4", out4, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fresh block after the abort.
    k = {4{32'h1357_9BDF}};
    b = 64'h0011_2233_4455_6677;
    run_block(k, b, 1'b1, tea_ref(k, b, 1'b1), 0, r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
